spi_slave_core: RTL and testbench

- MMIO-slot SPI slave (responder).
- Sits behind the same 5-bit-address, 32-bit-data slot bus as the SPI master core and faces an external SPI master.
- Receives MOSI bytes into a buffered RX register and shifts a CPU-preloaded TX byte out on MISO.
- Supports all four CPOL/CPHA modes. All logic is in the system clock domain; SPI inputs are oversampled.

---
 rtl/spi_slave_pkg.sv | 25 ++
 rtl/spi_slave_sync.sv | 41 ++++
 rtl/spi_slave_core.sv | 200 ++++++++++++++++++++
 tb/tb_spi_slave_core.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared constants and types for the SPI slave slot: register map, STATUS/CTRL
// bit positions and the transfer state encoding.
package spi_slave_pkg;

  localparam logic [4:0] REG_STATUS = 5'd0;
  localparam logic [4:0] REG_TXDATA = 5'd1;
  localparam logic [4:0] REG_RXDATA = 5'd2;
  localparam logic [4:0] REG_CTRL   = 5'd3;

  localparam int ST_RX_VALID = 0;
  localparam int ST_BUSY     = 1;
  localparam int ST_OVERRUN  = 2;
  localparam int ST_TX_EMPTY = 3;

  localparam int CTRL_CPHA    = 0;
  localparam int CTRL_CPOL    = 1;
  localparam int CTRL_OVR_CLR = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/spi_slave_sync.sv
// Multi-flop synchronizer for one SPI pin, with rise/fall detection taken from
// the last two synchronized samples.
module spi_slave_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_q, chain_d;
  logic              prev_q, prev_d;

  always_comb begin
    chain_d    = chain_q;
    chain_d[0] = din;
    for (int i = 1; i < STAGES; i++) begin
      chain_d[i] = chain_q[i-1];
    end
    prev_d = chain_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chain_q <= {STAGES{RST_VAL}};
      prev_q  <= RST_VAL;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

  assign dout = chain_q[STAGES-1];
  assign rise = dout & ~prev_q;
  assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_slave_core.sv
// MMIO-slot SPI slave: oversampled SPI pins, buffered RX byte, CPU-preloaded
// TX byte shifted out on MISO, all four CPOL/CPHA modes.
module spi_slave_core
  import spi_slave_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  reg_addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic        spi_clk,
  input  logic        spi_mosi,
  input  logic        spi_cs_n,
  output logic        spi_miso,
  output state_e      dbg_state
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_n_s, cs_n_rise, cs_n_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .din(spi_clk),
    .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
    .clk(clk), .reset(reset), .din(spi_cs_n),
    .dout(cs_n_s), .rise(cs_n_rise), .fall(cs_n_fall)
  );
  spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .din(spi_mosi),
    .dout(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_rx_q, shift_rx_d;
  logic [DATA_W-1:0] shift_tx_q, shift_tx_d;
  logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              overrun_q, overrun_d;
  logic              tx_empty_q, tx_empty_d;
  logic              miso_q, miso_d;
  logic [1:0]        ctrl_q, ctrl_d;

  logic cpha, cpol, leading, trailing, sample_edge, shift_edge;
  logic rd_rx, wr_tx, wr_ctrl;
  logic [3:0] status;

  assign cpha        = ctrl_q[CTRL_CPHA];
  assign cpol        = ctrl_q[CTRL_CPOL];
  assign leading     = cpol ? sclk_fall : sclk_rise;
  assign trailing    = cpol ? sclk_rise : sclk_fall;
  assign sample_edge = cpha ? trailing : leading;
  assign shift_edge  = cpha ? leading : trailing;

  assign rd_rx   = cs & read  & (reg_addr == REG_RXDATA);
  assign wr_tx   = cs & write & (reg_addr == REG_TXDATA);
  assign wr_ctrl = cs & write & (reg_addr == REG_CTRL);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_rx_d = shift_rx_q;
    shift_tx_d = shift_tx_q;
    tx_buf_d   = tx_buf_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    tx_empty_d = tx_empty_q;
    miso_d     = miso_q;
    ctrl_d     = ctrl_q;

    if (rd_rx) rx_valid_d = 1'b0;
    if (wr_ctrl) begin
      ctrl_d = wr_data[1:0];
      if (wr_data[CTRL_OVR_CLR]) overrun_d = 1'b0;
    end
    if (wr_tx) tx_buf_d = wr_data[DATA_W-1:0];

    unique case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_n_fall) begin
          shift_tx_d = tx_buf_q;
          tx_empty_d = 1'b1;
          bit_cnt_d  = '0;
          if (!cpha) miso_d = tx_buf_q[DATA_W-1];
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (cs_n_s) begin
          // Master gave up mid-byte: drop the partial byte silently.
          state_d   = IDLE;
          miso_d    = 1'b0;
          bit_cnt_d = '0;
        end else begin
          if (sample_edge) begin
            shift_rx_d = {shift_rx_q[DATA_W-2:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(DATA_W - 1)) state_d = DONE;
          end
          // cpha=0 already presented the MSB, so the trailing edge that closes
          // the previous byte (bit_cnt back at 0) must not advance the new one.
          if (shift_edge) begin
            if (cpha) begin
              miso_d     = shift_tx_q[DATA_W-1];
              shift_tx_d = shift_tx_q << 1;
            end else if (bit_cnt_q != '0) begin
              miso_d     = shift_tx_q[DATA_W-2];
              shift_tx_d = shift_tx_q << 1;
            end
          end
        end
      end
      DONE: begin
        rx_data_d  = shift_rx_q;
        rx_valid_d = 1'b1;
        if (rx_valid_q && !rd_rx) overrun_d = 1'b1;
        bit_cnt_d  = '0;
        shift_tx_d = tx_empty_q ? '0 : tx_buf_q;
        tx_empty_d = 1'b1;
        if (cs_n_s) begin
          state_d = IDLE;
          miso_d  = 1'b0;
        end else begin
          state_d = ACTIVE;
          if (!cpha) miso_d = tx_empty_q ? 1'b0 : tx_buf_q[DATA_W-1];
        end
      end
      default: state_d = IDLE;
    endcase

    // A write landing on a reload cycle keeps its data pending for the next byte.
    if (wr_tx) tx_empty_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_rx_q <= '0;
      shift_tx_q <= '0;
      tx_buf_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      tx_empty_q <= 1'b1;
      miso_q     <= 1'b0;
      ctrl_q     <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_rx_q <= shift_rx_d;
      shift_tx_q <= shift_tx_d;
      tx_buf_q   <= tx_buf_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      tx_empty_q <= tx_empty_d;
      miso_q     <= miso_d;
      ctrl_q     <= ctrl_d;
    end
  end

  always_comb begin
    status              = '0;
    status[ST_RX_VALID] = rx_valid_q;
    status[ST_BUSY]     = (state_q != IDLE);
    status[ST_OVERRUN]  = overrun_q;
    status[ST_TX_EMPTY] = tx_empty_q;
  end

  always_comb begin
    rd_data = '0;
    case (reg_addr)
      REG_STATUS: rd_data = {28'd0, status};
      REG_RXDATA: rd_data = {{(32-DATA_W){1'b0}}, rx_data_q};
      REG_CTRL:   rd_data = {30'd0, ctrl_q};
      default:    rd_data = '0;
    endcase
  end

  assign spi_miso  = miso_q;
  assign dbg_state = state_q;

  logic unused_bits;
  assign unused_bits = ^{sclk_s, cs_n_rise, mosi_rise, mosi_fall, wr_data[31:DATA_W]};

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: bit-banged SPI master in all four modes against a
// byte-level model of the slot registers.
module tb_spi_slave_core;
  import spi_slave_pkg::*;

  localparam int HALF = 4;

  logic        clk = 1'b0;
  logic        reset, cs, read, write;
  logic [4:0]  reg_addr;
  logic [31:0] wr_data, rd_data;
  logic        spi_clk, spi_mosi, spi_cs_n, spi_miso;
  state_e      dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  spi_slave_core #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
    .reg_addr(reg_addr), .wr_data(wr_data), .rd_data(rd_data),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
    .spi_miso(spi_miso), .dbg_state(dbg_state)
  );

  // Byte-level reference model of the slot registers.
  logic [7:0] m_rx_data, m_tx_buf, m_coll_exp;
  logic       m_rx_valid, m_overrun, m_tx_empty;
  logic [1:0] m_ctrl;
  logic [7:0] exp_q[$];
  logic [7:0] mosi_arr[8];
  logic [7:0] miso_arr[8];
  logic [7:0] coll_rd;
  logic       lat_a, lat_b, rst_miso;
  logic [31:0] rst_status;

  function automatic void model_reset();
    m_rx_data = 8'h00; m_tx_buf = 8'h00; m_rx_valid = 1'b0;
    m_overrun = 1'b0; m_tx_empty = 1'b1; m_ctrl = 2'b00;
  endfunction

  function automatic logic [31:0] m_status();
    return {28'd0, m_tx_empty, m_overrun, 1'b0, m_rx_valid};
  endfunction

  function automatic void model_frame(input int nbytes, input int abort_bits, input bit coll);
    exp_q.delete();
    for (int k = 0; k < nbytes; k++) begin
      exp_q.push_back((k == 0 || !m_tx_empty) ? m_tx_buf : 8'h00);
      m_tx_empty = 1'b1;
      if (abort_bits == 0) begin
        if (coll && k == nbytes - 1) m_coll_exp = m_rx_data;
        else if (m_rx_valid) m_overrun = 1'b1;
        m_rx_valid = 1'b1;
        m_rx_data  = mosi_arr[k];
      end
    end
  endfunction

  task automatic cpu_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk); cs = 1'b1; write = 1'b1; reg_addr = a; wr_data = d;
    @(negedge clk); cs = 1'b0; write = 1'b0; reg_addr = REG_STATUS; wr_data = '0;
    if (a == REG_TXDATA) begin m_tx_buf = d[7:0]; m_tx_empty = 1'b0; end
    if (a == REG_CTRL) begin m_ctrl = d[1:0]; if (d[2]) m_overrun = 1'b0; end
  endtask

  task automatic cpu_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk); cs = 1'b1; read = 1'b1; reg_addr = a;
    #1 d = rd_data;
    @(negedge clk); cs = 1'b0; read = 1'b0; reg_addr = REG_STATUS;
    if (a == REG_RXDATA) m_rx_valid = 1'b0;
  endtask

  // Half SPI period following a sampling edge; on the final byte the DONE
  // cycle is the posedge between the 3rd and 4th negedge.
  task automatic done_window(input bit last, input int act);
    for (int i = 1; i <= HALF; i++) begin
      @(negedge clk);
      if (last && act == 1 && i == 3) begin
        cs = 1'b1; read = 1'b1; reg_addr = REG_RXDATA;
        #1 coll_rd = rd_data[7:0];
      end
      if (last && act == 1 && i == 4) begin
        cs = 1'b0; read = 1'b0; reg_addr = REG_STATUS;
      end
      if (last && act == 2 && i == 3) begin #1 lat_a = rd_data[ST_RX_VALID]; end
      if (last && act == 2 && i == 4) begin #1 lat_b = rd_data[ST_RX_VALID]; end
    end
  endtask

  task automatic spi_frame(input int nbytes, input int abort_bits, input int done_act, input bit rst_mid);
    int total;
    logic cpha, cpol;
    cpha = m_ctrl[0];
    cpol = m_ctrl[1];
    total = (abort_bits > 0) ? abort_bits : nbytes * 8;
    for (int k = 0; k < 8; k++) miso_arr[k] = 8'h00;
    spi_clk = cpol; spi_mosi = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int b = 0; b < total; b++) begin
      int by, bi;
      bit last;
      by = b / 8;
      bi = 7 - (b % 8);
      last = (b == total - 1) && (abort_bits == 0);
      if (!cpha) begin
        spi_mosi = mosi_arr[by][bi];
        repeat (HALF) @(negedge clk);
        spi_clk = ~cpol;
        miso_arr[by][bi] = spi_miso;
        done_window(last, done_act);
        spi_clk = cpol;
      end else begin
        spi_clk = ~cpol;
        spi_mosi = mosi_arr[by][bi];
        repeat (HALF) @(negedge clk);
        spi_clk = cpol;
        miso_arr[by][bi] = spi_miso;
        done_window(last, done_act);
      end
    end
    repeat (HALF) @(negedge clk);
    if (rst_mid) begin
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      #1 rst_status = rd_data;
      rst_miso = spi_miso;
    end
    spi_cs_n = 1'b1;
    spi_clk = m_ctrl[1];
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    n_checks++; if (spi_miso !== 1'b0) $display("FAIL reset_miso: got %b want 0", spi_miso); else n_pass++;
    n_checks++; if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); else n_pass++;
    cpu_read(REG_STATUS, d);
    n_checks++; if (d !== m_status()) $display("FAIL reset_status: got %h want %h", d, m_status()); else n_pass++;
    cpu_read(REG_RXDATA, d);
    n_checks++; if (d !== 32'(m_rx_data)) $display("FAIL reset_rxdata: got %h want %h", d, m_rx_data); else n_pass++;
    cpu_read(REG_CTRL, d);
    n_checks++; if (d !== 32'(m_ctrl)) $display("FAIL reset_ctrl: got %h want %h", d, m_ctrl); else n_pass++;
  endtask

  task automatic test_mode0;
    logic [31:0] d;
    cpu_write(REG_CTRL, 32'h0);
    cpu_write(REG_TXDATA, 32'hA5);
    mosi_arr[0] = 8'h3C;
    model_frame(1, 0, 0);
    spi_frame(1, 0, 2, 0);
    n_checks++; if (miso_arr[0] !== exp_q[0]) $display("FAIL mode0_miso: got %h want %h", miso_arr[0], exp_q[0]); else n_pass++;
    n_checks++; if (lat_a !== 1'b0) $display("FAIL mode0_latency_early: got %b want 0", lat_a); else n_pass++;
    n_checks++; if (lat_b !== 1'b1) $display("FAIL mode0_latency_on_time: got %b want 1", lat_b); else n_pass++;
    cpu_read(REG_STATUS, d);
    n_checks++; if (d !== m_status()) $display("FAIL mode0_status: got %h want %h", d, m_status()); else n_pass++;
    cpu_read(REG_RXDATA, d);
    n_checks++; if (d !== 32'(m_rx_data)) $display("FAIL mode0_rxdata: got %h want %h", d, m_rx_data); else n_pass++;
    cpu_read(REG_STATUS, d);
    n_checks++; if (d !== m_status()) $display("FAIL mode0_status_after_rd: got %h want %h", d, m_status()); else n_pass++;
  endtask

  task automatic test_modes;
    logic [31:0] d;
    for (int m = 0; m < 4; m++) begin
      cpu_write(REG_CTRL, 32'(m));
      cpu_write(REG_TXDATA, 32'hC3);
      mosi_arr[0] = 8'h5A;
      model_frame(1, 0, 0);
      spi_frame(1, 0, 0, 0);
      cpu_read(REG_CTRL, d);
      n_checks++; if (d !== 32'(m_ctrl)) $display("FAIL modes_ctrl m=%0d: got %h want %h", m, d, m_ctrl); else n_pass++;
      n_checks++; if (miso_arr[0] !== exp_q[0]) $display("FAIL modes_miso m=%0d: got %h want %h", m, miso_arr[0], exp_q[0]); else n_pass++;
      cpu_read(REG_RXDATA, d);
      n_checks++; if (d !== 32'(m_rx_data)) $display("FAIL modes_rxdata m=%0d: got %h want %h", m, d, m_rx_data); else n_pass++;
    end
  endtask

  task automatic test_overrun;
    logic [31:0] d;
    cpu_write(REG_CTRL, 32'h0);
    cpu_write(REG_TXDATA, 32'($urandom_range(0, 255)));
    mosi_arr[0] = 8'h11; mosi_arr[1] = 8'h22;
    model_frame(2, 0, 0);
    spi_frame(2, 0, 0, 0);
    cpu_read(REG_STATUS, d);
    n_checks++; if (d !== m_status()) $display("FAIL overrun_status: got %h want %h", d, m_status()); else n_pass++;
    cpu_read(REG_RXDATA, d);
    n_checks++; if (d !== 32'(m_rx_data)) $display("FAIL overrun_rxdata: got %h want %h", d, m_rx_data); else n_pass++;
    cpu_write(REG_CTRL, 32'h4);
    cpu_read(REG_STATUS, d);
    n_checks++; if (d !== m_status()) $display("FAIL overrun_clear: got %h want %h", d, m_status()); else n_pass++;
  endtask

  task automatic test_abort;
    logic [31:0] d;
    cpu_write(REG_CTRL, 32'h0);
    cpu_write(REG_TXDATA, 32'($urandom_range(0, 255)));
    mosi_arr[0] = 8'($urandom_range(0, 255));
    model_frame(1, 5, 0);
    spi_frame(1, 5, 0, 0);
    cpu_read(REG_STATUS, d);
    n_checks++; if (d !== m_status()) $display("FAIL abort_status: got %h want %h", d, m_status()); else n_pass++;
    cpu_write(REG_TXDATA, 32'($urandom_range(0, 255)));
    mosi_arr[0] = 8'h7E;
    model_frame(1, 0, 0);
    spi_frame(1, 0, 0, 0);
    n_checks++; if (miso_arr[0] !== exp_q[0]) $display("FAIL abort_next_miso: got %h want %h", miso_arr[0], exp_q[0]); else n_pass++;
    cpu_read(REG_RXDATA, d);
    n_checks++; if (d !== 32'(m_rx_data)) $display("FAIL abort_next_rxdata: got %h want %h", d, m_rx_data); else n_pass++;
  endtask

  task automatic test_underrun_collision;
    logic [31:0] d;
    cpu_write(REG_CTRL, 32'h0);
    cpu_read(REG_RXDATA, d);
    cpu_write(REG_TXDATA, 32'h99);
    mosi_arr[0] = 8'($urandom_range(0, 255));
    mosi_arr[1] = 8'($urandom_range(0, 255));
    model_frame(2, 0, 1);
    spi_frame(2, 0, 1, 0);
    n_checks++; if (miso_arr[0] !== exp_q[0]) $display("FAIL underrun_miso0: got %h want %h", miso_arr[0], exp_q[0]); else n_pass++;
    n_checks++; if (miso_arr[1] !== exp_q[1]) $display("FAIL underrun_miso1: got %h want %h", miso_arr[1], exp_q[1]); else n_pass++;
    n_checks++; if (coll_rd !== m_coll_exp) $display("FAIL collision_rd: got %h want %h", coll_rd, m_coll_exp); else n_pass++;
    cpu_read(REG_STATUS, d);
    n_checks++; if (d !== m_status()) $display("FAIL collision_status: got %h want %h", d, m_status()); else n_pass++;
    cpu_read(REG_RXDATA, d);
    n_checks++; if (d !== 32'(m_rx_data)) $display("FAIL collision_rxdata: got %h want %h", d, m_rx_data); else n_pass++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    cpu_write(REG_CTRL, 32'h0);
    cpu_write(REG_TXDATA, 32'h3A);
    mosi_arr[0] = 8'($urandom_range(0, 255));
    model_frame(1, 0, 0);
    spi_frame(1, 0, 0, 0);
    cpu_write(REG_TXDATA, 32'($urandom_range(0, 255)));
    mosi_arr[0] = 8'($urandom_range(0, 255));
    spi_frame(1, 3, 0, 1);
    n_checks++; if (rst_status !== m_status()) $display("FAIL rstmid_status: got %h want %h", rst_status, m_status()); else n_pass++;
    n_checks++; if (rst_miso !== 1'b0) $display("FAIL rstmid_miso: got %b want 0", rst_miso); else n_pass++;
    cpu_read(REG_RXDATA, d);
    n_checks++; if (d !== 32'(m_rx_data)) $display("FAIL rstmid_rxdata: got %h want %h", d, m_rx_data); else n_pass++;
    cpu_read(REG_STATUS, d);
    n_checks++; if (d !== m_status()) $display("FAIL rstmid_status_idle: got %h want %h", d, m_status()); else n_pass++;
    cpu_write(REG_TXDATA, 32'($urandom_range(0, 255)));
    mosi_arr[0] = 8'($urandom_range(0, 255));
    model_frame(1, 0, 0);
    spi_frame(1, 0, 0, 0);
    n_checks++; if (miso_arr[0] !== exp_q[0]) $display("FAIL rstmid_next_miso: got %h want %h", miso_arr[0], exp_q[0]); else n_pass++;
    cpu_read(REG_RXDATA, d);
    n_checks++; if (d !== 32'(m_rx_data)) $display("FAIL rstmid_next_rxdata: got %h want %h", d, m_rx_data); else n_pass++;
  endtask

  task automatic test_random;
    logic [31:0] d;
    for (int it = 0; it < 8; it++) begin
      int nb, mode, clr;
      mode = $urandom_range(0, 3);
      clr  = $urandom_range(0, 1);
      cpu_write(REG_CTRL, 32'(mode) | (clr != 0 ? 32'h4 : 32'h0));
      if ($urandom_range(0, 3) != 0) cpu_write(REG_TXDATA, 32'($urandom_range(0, 255)));
      nb = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++) mosi_arr[k] = 8'($urandom_range(0, 255));
      model_frame(nb, 0, 0);
      spi_frame(nb, 0, 0, 0);
      for (int k = 0; k < nb; k++) begin
        n_checks++; if (miso_arr[k] !== exp_q[k]) $display("FAIL rand_miso it=%0d k=%0d: got %h want %h", it, k, miso_arr[k], exp_q[k]); else n_pass++;
      end
      cpu_read(REG_STATUS, d);
      n_checks++; if (d !== m_status()) $display("FAIL rand_status it=%0d: got %h want %h", it, d, m_status()); else n_pass++;
      if ($urandom_range(0, 1) == 1) begin
        cpu_read(REG_RXDATA, d);
        n_checks++; if (d !== 32'(m_rx_data)) $display("FAIL rand_rxdata it=%0d: got %h want %h", it, d, m_rx_data); else n_pass++;
      end
    end
  endtask

  initial begin
    reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0;
    reg_addr = REG_STATUS; wr_data = '0;
    spi_clk = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1;
    model_reset();
    test_reset();
    test_mode0();
    test_modes();
    test_overrun();
    test_abort();
    test_underrun_collision();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
